// File: rtl/prog_loader_pkg.sv
// Shared types, character constants and sizing helpers for the program loader.
package prog_loader_pkg;

    // Loader FSM states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEP   = 3'd1,
        ST_WORD  = 3'd2,
        ST_ADDR  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    // Control and separator characters of the hex image format.
    localparam logic [7:0] CH_AT  = 8'h40;
    localparam logic [7:0] CH_EOT = 8'h04;
    localparam logic [7:0] CH_SP  = 8'h20;
    localparam logic [7:0] CH_TAB = 8'h09;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_CR  = 8'h0D;

    // Number of hex digits needed to express a value of the given bit width.
    function automatic int hex_digits(input int bits);
        return (bits + 3) / 4;
    endfunction

endpackage

// File: rtl/hex_char_decode.sv
// Combinational classifier for one ASCII character of the hex image.
module hex_char_decode
    import prog_loader_pkg::*;
(
    input  logic [7:0] ch,
    output logic       is_hex,
    output logic       is_ws,
    output logic       is_at,
    output logic       is_eot,
    output logic [3:0] value
);

    // Hex digit detection and nibble value; letters map 'A'/'a' (low nibble 1) to 10.
    always_comb begin
        is_hex = 1'b0;
        value  = 4'h0;
        if ((ch >= 8'h30) && (ch <= 8'h39)) begin
            is_hex = 1'b1;
            value  = ch[3:0];
        end else if ((ch >= 8'h41) && (ch <= 8'h46)) begin
            is_hex = 1'b1;
            value  = ch[3:0] + 4'd9;
        end else if ((ch >= 8'h61) && (ch <= 8'h66)) begin
            is_hex = 1'b1;
            value  = ch[3:0] + 4'd9;
        end else begin
            is_hex = 1'b0;
            value  = 4'h0;
        end
    end

    // Separator and control character detection.
    always_comb begin
        is_ws  = 1'b0;
        is_at  = 1'b0;
        is_eot = 1'b0;
        case (ch)
            CH_SP, CH_TAB, CH_LF, CH_CR: is_ws  = 1'b1;
            CH_AT:                       is_at  = 1'b1;
            CH_EOT:                      is_eot = 1'b1;
            default: begin
                is_ws  = 1'b0;
                is_at  = 1'b0;
                is_eot = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/prog_loader.sv
// Program-memory loader: parses an ASCII hex image one character at a time and
// writes assembled instruction words sequentially into the program memory.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int Psize = 4,
    parameter int Isize = 15
)
(
    input  logic             clk,
    input  logic             n_reset,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             mem_we,
    output logic [Psize-1:0] mem_addr,
    output logic [Isize:0]   mem_wdata,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int DW    = hex_digits(Isize + 1);
    localparam int AW    = hex_digits(Psize);
    localparam int MAXD  = (DW > AW) ? DW : AW;
    // At least two digits wide so the shift slice below is always legal.
    localparam int ACC_W = 4 * ((MAXD > 2) ? MAXD : 2);
    localparam int CNT_W = $clog2(MAXD + 1) + 1;

    localparam logic [CNT_W-1:0] DW_C   = CNT_W'(DW);
    localparam logic [CNT_W-1:0] AW_C   = CNT_W'(AW);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C = CNT_W'(0);
    localparam logic [Psize-1:0] PTR_MAX = {Psize{1'b1}};

    state_t             state_r, state_nxt;
    logic [ACC_W-1:0]   acc_r, acc_nxt;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt;
    logic [Psize-1:0]   ptr_r, ptr_nxt;
    logic               full_r, full_nxt;
    logic               eot_r, eot_nxt;
    logic               error_r, error_nxt;

    logic               rdy_r;
    logic               mem_we_r;
    logic [Psize-1:0]   mem_addr_r;
    logic [Isize:0]     mem_wdata_r;
    logic               done_r;
    logic               busy_r;

    logic               is_hex_s, is_ws_s, is_at_s, is_eot_s;
    logic [3:0]         dig_s;
    logic               take_s;
    logic [ACC_W-1:0]   acc_shift_s;
    logic [ACC_W-1:0]   acc_digit_s;
    logic               addr_ovf_s;

    hex_char_decode u_dec (
        .ch     (in_data),
        .is_hex (is_hex_s),
        .is_ws  (is_ws_s),
        .is_at  (is_at_s),
        .is_eot (is_eot_s),
        .value  (dig_s)
    );

    assign take_s      = in_valid & rdy_r;
    assign acc_shift_s = {acc_r[ACC_W-5:0], dig_s};
    assign acc_digit_s = {{(ACC_W-4){1'b0}}, dig_s};
    // Address token value does not fit the program memory.
    assign addr_ovf_s  = ((acc_r >> Psize) != {ACC_W{1'b0}});

    // State register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state and datapath update decode.
    always_comb begin
        state_nxt = state_r;
        acc_nxt   = acc_r;
        cnt_nxt   = cnt_r;
        ptr_nxt   = ptr_r;
        full_nxt  = full_r;
        eot_nxt   = eot_r;
        error_nxt = error_r;
        case (state_r)
            ST_IDLE: begin
                if (take_s && !is_ws_s && !is_eot_s) begin
                    // A new load starts: rewind and handle the char as a separator-state char.
                    ptr_nxt   = {Psize{1'b0}};
                    full_nxt  = 1'b0;
                    error_nxt = 1'b0;
                    if (is_hex_s) begin
                        acc_nxt   = acc_digit_s;
                        cnt_nxt   = ONE_C;
                        state_nxt = ST_WORD;
                    end else if (is_at_s) begin
                        acc_nxt   = {ACC_W{1'b0}};
                        cnt_nxt   = ZERO_C;
                        state_nxt = ST_ADDR;
                    end else begin
                        state_nxt = ST_ERR;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SEP: begin
                if (!take_s || is_ws_s) begin
                    state_nxt = ST_SEP;
                end else if (is_hex_s) begin
                    // A word after the last address would wrap; refuse it.
                    if (full_r) begin
                        state_nxt = ST_ERR;
                    end else begin
                        acc_nxt   = acc_digit_s;
                        cnt_nxt   = ONE_C;
                        state_nxt = ST_WORD;
                    end
                end else if (is_at_s) begin
                    acc_nxt   = {ACC_W{1'b0}};
                    cnt_nxt   = ZERO_C;
                    state_nxt = ST_ADDR;
                end else if (is_eot_s) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_ERR;
                end
            end
            ST_WORD: begin
                if (!take_s) begin
                    state_nxt = ST_WORD;
                end else if (is_hex_s) begin
                    if (cnt_r == DW_C) begin
                        state_nxt = ST_ERR;
                    end else begin
                        acc_nxt = acc_shift_s;
                        cnt_nxt = cnt_r + ONE_C;
                    end
                end else if (is_ws_s) begin
                    eot_nxt   = 1'b0;
                    state_nxt = ST_WRITE;
                end else if (is_eot_s) begin
                    eot_nxt   = 1'b1;
                    state_nxt = ST_WRITE;
                end else begin
                    state_nxt = ST_ERR;
                end
            end
            ST_ADDR: begin
                if (!take_s) begin
                    state_nxt = ST_ADDR;
                end else if (is_hex_s) begin
                    if (cnt_r == AW_C) begin
                        state_nxt = ST_ERR;
                    end else begin
                        acc_nxt = acc_shift_s;
                        cnt_nxt = cnt_r + ONE_C;
                    end
                end else if (is_ws_s) begin
                    if ((cnt_r == ZERO_C) || addr_ovf_s) begin
                        state_nxt = ST_ERR;
                    end else begin
                        ptr_nxt   = acc_r[Psize-1:0];
                        full_nxt  = 1'b0;
                        state_nxt = ST_SEP;
                    end
                end else begin
                    state_nxt = ST_ERR;
                end
            end
            ST_WRITE: begin
                // The last address is written once and then marked full instead of wrapping.
                if (ptr_r == PTR_MAX) begin
                    full_nxt = 1'b1;
                end else begin
                    ptr_nxt = ptr_r + {{(Psize-1){1'b0}}, 1'b1};
                end
                state_nxt = eot_r ? ST_DONE : ST_SEP;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                // Drain everything until the end-of-transmission marker.
                if (take_s && is_eot_s) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_ERR;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        error_nxt = (state_nxt == ST_ERR) ? 1'b1 : error_nxt;
    end

    // Accumulator, digit counter, pointer, full flag and error flag registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            acc_r   <= {ACC_W{1'b0}};
            cnt_r   <= ZERO_C;
            ptr_r   <= {Psize{1'b0}};
            full_r  <= 1'b0;
            eot_r   <= 1'b0;
            error_r <= 1'b0;
        end else begin
            acc_r   <= acc_nxt;
            cnt_r   <= cnt_nxt;
            ptr_r   <= ptr_nxt;
            full_r  <= full_nxt;
            eot_r   <= eot_nxt;
            error_r <= error_nxt;
        end
    end

    // Registered outputs decoded from the next state so they line up with state_r.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rdy_r       <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {Psize{1'b0}};
            mem_wdata_r <= {(Isize+1){1'b0}};
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            rdy_r    <= (state_nxt != ST_WRITE) && (state_nxt != ST_DONE);
            mem_we_r <= (state_nxt == ST_WRITE);
            done_r   <= (state_nxt == ST_DONE);
            busy_r   <= (state_nxt != ST_IDLE);
            if (state_nxt == ST_WRITE) begin
                mem_addr_r  <= ptr_r;
                mem_wdata_r <= acc_r[Isize:0];
            end else begin
                mem_addr_r  <= mem_addr_r;
                mem_wdata_r <= mem_wdata_r;
            end
        end
    end

    assign in_ready  = rdy_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign error     = error_r;

endmodule
